// File: rtl/sparse_systolic_tile_if.sv
// rtl/sparse_systolic_tile_if.sv - control, weight, activation and result streams of the sparse systolic tile
interface sparse_systolic_tile_if #(
  parameter int N_ROWS = 14,
  parameter int N_COLS = 14,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 16
) ();
  logic                       start;
  logic [K_W-1:0]             cfg_k;
  logic                       busy;
  logic                       done;
  logic                       wgt_valid;
  logic                       wgt_ready;
  logic [N_COLS*DATA_W-1:0]   wgt_data;
  logic                       act_valid;
  logic                       act_ready;
  logic [N_ROWS*DATA_W-1:0]   act_data;
  logic                       act_zero;
  logic                       res_valid;
  logic                       res_ready;
  logic [$clog2(N_ROWS)-1:0]  res_row;
  logic [N_COLS*ACC_W-1:0]    res_data;
  logic [K_W-1:0]             skip_count;

  modport master (
    output start, cfg_k, wgt_valid, wgt_data, act_valid, act_data, act_zero, res_ready,
    input  busy, done, wgt_ready, act_ready, res_valid, res_row, res_data, skip_count
  );

  modport slave (
    input  start, cfg_k, wgt_valid, wgt_data, act_valid, act_data, act_zero, res_ready,
    output busy, done, wgt_ready, act_ready, res_valid, res_row, res_data, skip_count
  );
endinterface

// File: rtl/sparse_systolic_tile.sv
// rtl/sparse_systolic_tile.sv - output-stationary sparse MAC array with load/stream/flush/drain control
module sparse_systolic_tile #(
  parameter int N_ROWS = 14,
  parameter int N_COLS = 14,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sparse_systolic_tile_if.slave bus
);
  localparam int RW = $clog2(N_ROWS);
  localparam int CW = $clog2(N_COLS);
  localparam int PW = 2 * DATA_W;
  localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, FLUSH, DRAIN} state_t;

  state_t         state;
  logic [RW-1:0]  row_ptr;
  logic [K_W-1:0] k_q;
  logic [K_W-1:0] beat_cnt;
  logic [K_W-1:0] skip_q;
  logic [CW-1:0]  flush_cnt;
  logic           busy_q, done_q, wgt_ready_q, act_ready_q, res_valid_q;

  logic signed [DATA_W-1:0] w      [N_ROWS][N_COLS];
  logic signed [DATA_W-1:0] a_data [N_ROWS][N_COLS];
  logic                     a_vld  [N_ROWS][N_COLS];
  logic signed [PW-1:0]     prod   [N_ROWS][N_COLS];
  logic signed [ACC_W-1:0]  acc    [N_ROWS][N_COLS];
  logic [N_COLS*ACC_W-1:0]  res_mux;

  logic start_acc, wgt_fire, act_fire, res_fire, inject;

  assign start_acc = (state == IDLE) && bus.start;
  assign wgt_fire  = wgt_ready_q && bus.wgt_valid;
  assign act_fire  = act_ready_q && bus.act_valid;
  assign res_fire  = res_valid_q && bus.res_ready;
  assign inject    = act_fire && !bus.act_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_ptr     <= '0;
      k_q         <= '0;
      beat_cnt    <= '0;
      skip_q      <= '0;
      flush_cnt   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wgt_ready_q <= 1'b0;
      act_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= LOAD_W;
            k_q         <= bus.cfg_k;
            skip_q      <= '0;
            row_ptr     <= '0;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            busy_q      <= 1'b1;
            wgt_ready_q <= 1'b1;
          end
        end
        LOAD_W: begin
          if (wgt_fire) begin
            if (row_ptr == LAST_ROW) begin
              row_ptr     <= '0;
              wgt_ready_q <= 1'b0;
              if (k_q == '0) begin
                state <= FLUSH;
              end else begin
                state       <= STREAM;
                act_ready_q <= 1'b1;
              end
            end else begin
              row_ptr <= row_ptr + RW'(1);
            end
          end
        end
        STREAM: begin
          if (act_fire) begin
            beat_cnt <= beat_cnt + K_W'(1);
            if (bus.act_zero) skip_q <= skip_q + K_W'(1);
            if (beat_cnt == k_q - K_W'(1)) begin
              state       <= FLUSH;
              act_ready_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // N_COLS cycles lets the final injected vector reach the last column.
          if (flush_cnt == LAST_COL) begin
            flush_cnt   <= '0;
            state       <= DRAIN;
            res_valid_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (res_fire) begin
            if (row_ptr == LAST_ROW) begin
              row_ptr     <= '0;
              res_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state       <= IDLE;
            end else begin
              row_ptr <= row_ptr + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weights are fully rewritten every tile, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wgt_fire) begin
      for (int r = 0; r < N_ROWS; r++) begin
        if (row_ptr == RW'(r)) begin
          for (int c = 0; c < N_COLS; c++) begin
            w[r][c] <= bus.wgt_data[c*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < N_ROWS; r++) begin
      a_data[r][0] <= bus.act_data[r*DATA_W +: DATA_W];
      for (int c = 1; c < N_COLS; c++) begin
        a_data[r][c] <= a_data[r][c-1];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_COLS; c++) begin
        prod[r][c] = PW'(a_data[r][c]) * PW'(w[r][c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          a_vld[r][c] <= 1'b0;
          acc[r][c]   <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N_ROWS; r++) begin
        a_vld[r][0] <= inject;
        for (int c = 1; c < N_COLS; c++) begin
          a_vld[r][c] <= a_vld[r][c-1];
        end
        for (int c = 0; c < N_COLS; c++) begin
          if (a_vld[r][c]) acc[r][c] <= acc[r][c] + ACC_W'(prod[r][c]);
        end
      end
    end
  end

  always_comb begin
    res_mux = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (row_ptr == RW'(r)) begin
        for (int c = 0; c < N_COLS; c++) begin
          res_mux[c*ACC_W +: ACC_W] = acc[r][c];
        end
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wgt_ready  = wgt_ready_q;
  assign bus.act_ready  = act_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_row    = row_ptr;
  assign bus.res_data   = res_mux;
  assign bus.skip_count = skip_q;
endmodule

// File: tb/tb_sparse_systolic_tile.sv
// tb/tb_sparse_systolic_tile.sv - scoreboard bench for sparse_systolic_tile with a sum-of-products reference
module tb_sparse_systolic_tile;
  localparam int NR = 3;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_systolic_tile_if #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) bus ();

  sparse_systolic_tile #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int               row;
    logic [NC*AW-1:0] data;
  } res_t;

  res_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  int     ready_mode = 0;
  int     hold_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // 0: always ready, 1: random backpressure, 2: hold low 5 cycles on row 1
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: bus.res_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (bus.res_valid && bus.res_row == 1 && hold_cnt < 5) begin
          bus.res_ready = 1'b0;
          hold_cnt++;
        end else begin
          bus.res_ready = 1'b1;
        end
      end
      default: bus.res_ready = 1'b1;
    endcase
  end

  bit               prev_stall = 1'b0;
  logic [NC*AW-1:0] prev_data;
  int               prev_row;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(bus.res_valid), 64'd1);
        check("stall_row", 64'(bus.res_row), 64'(prev_row));
        check("stall_data", bus.res_data, prev_data);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result_row", 64'(bus.res_row), 64'hffff_ffff);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("res_row", 64'(bus.res_row), 64'(e.row));
          check("res_data", bus.res_data, e.data);
        end
      end
      prev_stall = bus.res_valid && !bus.res_ready;
      prev_data  = bus.res_data;
      prev_row   = int'(bus.res_row);
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_wgt_ready"}, 64'(bus.wgt_ready), 64'd0);
    check({tag, "_act_ready"}, 64'(bus.act_ready), 64'd0);
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_res_row"}, 64'(bus.res_row), 64'd0);
    check({tag, "_res_data"}, bus.res_data, 64'd0);
    check({tag, "_skip_count"}, 64'(bus.skip_count), 64'd0);
  endtask

  // kind 0: random with random zero vectors, 1: all -128 operands, 2: random with only the middle vector zero
  task automatic run_tile(input int k, input int kind, input bit gaps, input bit abort_mid, input bit chk_lat);
    int     wv[NR][NC];
    int     av[NR];
    longint accm[NR][NC];
    int     skips;
    bit     zero, got;
    longint s_cyc, d_cyc;
    res_t   e;
    skips = 0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        wv[r][c]   = (kind == 1) ? -128 : int'($urandom_range(0, 255)) - 128;
        accm[r][c] = 0;
      end
    end
    bus.cfg_k = KW'(k);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    s_cyc = cyc;
    for (int r = 0; r < NR; r++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      for (int c = 0; c < NC; c++) bus.wgt_data[c*DW +: DW] = wv[r][c][DW-1:0];
      bus.wgt_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk); got = bus.wgt_ready;
        @(posedge clk); #1;
      end
      bus.wgt_valid = 1'b0;
      if (!got) check("wgt_accept_timeout", 64'd0, 64'd1);
    end
    for (int i = 0; i < k; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      case (kind)
        1:       zero = 1'b0;
        2:       zero = (i == k / 2);
        default: zero = ($urandom_range(0, 3) == 0);
      endcase
      for (int r = 0; r < NR; r++) begin
        if (zero)           av[r] = int'($urandom_range(1, 127));
        else if (kind == 1) av[r] = -128;
        else                av[r] = int'($urandom_range(0, 255)) - 128;
        bus.act_data[r*DW +: DW] = av[r][DW-1:0];
      end
      bus.act_zero  = zero;
      bus.act_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk); got = bus.act_ready;
        @(posedge clk); #1;
      end
      bus.act_valid = 1'b0;
      bus.act_zero  = 1'b0;
      if (!got) check("act_accept_timeout", 64'd0, 64'd1);
      if (zero) begin
        skips++;
      end else begin
        for (int r = 0; r < NR; r++)
          for (int c = 0; c < NC; c++)
            accm[r][c] += longint'(av[r]) * longint'(wv[r][c]);
      end
      if (abort_mid && i == k / 2) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        reset_checks("mid_reset");
        return;
      end
    end
    for (int r = 0; r < NR; r++) begin
      e.row = r;
      for (int c = 0; c < NC; c++) e.data[c*AW +: AW] = accm[r][c][AW-1:0];
      exp_q.push_back(e);
    end
    got = 1'b0;
    d_cyc = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        d_cyc = cyc;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    // latency counts the start cycle through the done cycle inclusive
    if (chk_lat) check("tile_latency", 64'(d_cyc - s_cyc + 1), 64'(2 * NR + k + NC + 1));
    check("skip_count", 64'(bus.skip_count), 64'(skips));
    check("busy_in_done_cycle", 64'(bus.busy), 64'd0);
    check("rows_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_pulse_width", 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.cfg_k     = '0;
    bus.wgt_valid = 1'b0;
    bus.wgt_data  = '0;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.act_zero  = 1'b0;
    bus.res_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    reset_checks("reset");

    run_tile(4, 0, 1'b0, 1'b0, 1'b1);
    run_tile(3, 2, 1'b0, 1'b0, 1'b1);
    run_tile(3, 1, 1'b0, 1'b0, 1'b1);
    run_tile(0, 0, 1'b0, 1'b0, 1'b1);

    hold_cnt = 0;
    ready_mode = 2;
    run_tile(5, 0, 1'b0, 1'b0, 1'b0);
    check("row1_hold_cycles", 64'(hold_cnt), 64'd5);
    ready_mode = 0;

    ready_mode = 1;
    for (int n = 0; n < 4; n++) run_tile(int'($urandom_range(1, 8)), 0, 1'b1, 1'b0, 1'b0);
    ready_mode = 0;

    run_tile(6, 0, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("no_result_after_abort", 64'(exp_q.size()), 64'd0);
    run_tile(4, 0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sparse_systolic_tile.md
# sparse_systolic_tile

Next-generation sparse systolic compute tile: N_ROWS×N_COLS output-stationary MAC array with an internal control FSM. It loads a weight tile row-by-row over a valid/ready stream and consumes K activation vectors over a second stream. All-zero activation vectors are skipped: no MAC, and a counter reports them. It then drains the accumulators row-by-row over a result stream. It sits between the act/wgt buffers and the output accumulation/quantisation stage, replacing the scheduler-driven block_valid/load_weight control with self-contained handshakes.

## Interface
- N_ROWS, 14, array rows (≥2)
- N_COLS, 14, array columns (≥2)
- DATA_W, 8, signed activation/weight width
- ACC_W, 32, accumulator width (≥2*DATA_W)
- K_W, 16, width of tile-depth config and counters
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset: synchronous, active-low
- start  in  1  begin a tile; sampled only in IDLE
- cfg_k  in  K_W  number of activation vectors in tile; latched on accepted start
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last result beat
- wgt_valid / wgt_ready  in / out  1  weight row handshake
- wgt_data  in  N_COLS*DATA_W  one weight row; column c at [c*DATA_W +: DATA_W]
- act_valid / act_ready  in / out  1  activation vector handshake
- act_data  in  N_ROWS*DATA_W  one activation vector; row r at [r*DATA_W +: DATA_W]
- act_zero  in  1  vector is all-zero; qualifies with act_valid
- res_valid / res_ready  out / in  1  result row handshake
- res_row  out  $clog2(N_ROWS)  row index of res_data
- res_data  out  N_COLS*ACC_W  accumulators of row res_row; column c at [c*ACC_W +: ACC_W]
- skip_count  out  K_W  zero vectors skipped in current/last tile

## Operation
- FSM states: IDLE, LOAD_W, STREAM, FLUSH, DRAIN.
- IDLE: start=1 → LOAD_W. Same edge: latch cfg_k, zero all accumulators, zero skip_count, zero row/beat counters. start ignored outside IDLE.
- LOAD_W: wgt_ready=1. Each wgt_valid&wgt_ready writes wgt_data into weight regs of row ptr, ptr++. On the N_ROWS-th beat: → STREAM, or → FLUSH if latched k==0.
- STREAM: act_ready=1 (never stalls). Each accepted beat increments beat count. On the cfg_k-th beat → FLUSH.
  - act_zero=0: inject vector with valid bit into column-0 stage.
  - act_zero=1: inject valid bit 0 (bubble); skip_count++ (wraps at 2^K_W).
- Array datapath: per row r, a (data, valid) pair shifts one column right per cycle, unconditionally in every state. PE[r][c] performs acc += sext(a*w[r][c]) only when its incoming valid bit=1. Product is signed 2*DATA_W, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W, no saturation.
- Pipeline valid bits cleared on reset and on accepted start. Weights are not cleared; they are fully overwritten in LOAD_W.
- FLUSH: N_COLS-cycle counter, guaranteeing the last injected vector reached column N_COLS-1. Then → DRAIN with row ptr=0.
- DRAIN: res_valid=1, res_row=ptr, res_data=acc row ptr (mux from stable regs). On res_valid&res_ready: ptr++. After the N_ROWS-th beat → IDLE, with done=1 for exactly that next cycle.
- res_data may be held indefinitely under backpressure; it must stay stable while res_valid=1 and res_ready=0.
- Accumulators and skip_count keep their values in IDLE until the next accepted start.
- Synchronous reset, including mid-tile: state=IDLE; all valids, readies, busy and done=0; counters, skip_count and accumulators=0. No partial results are emitted.

## Timing
- Reset values: busy=0, done=0, wgt_ready=0, act_ready=0, res_valid=0, res_row=0, res_data=0, skip_count=0.
- wgt_ready, act_ready, res_valid and busy are decoded from registered state; they rise on the cycle after the entering transition edge.
- Activation accepted at edge t: PE column c accumulates at edge t+1+c.
- Minimum tile latency from start edge to done cycle: N_ROWS + K + N_COLS + N_ROWS + 1 cycles, with all streams always ready/valid.
- Back-to-back tiles: start is accepted in the cycle done is high (state is IDLE).
- In STREAM, act_valid=0 cycles simply insert bubbles and do not advance the beat count.

## Test plan
- 2×2 (DATA_W=8), W=[[1,2],[3,4]], K=2, a0=[1,1], a1=[2,-1] → rows 0:[3,6], 1:[0,0]; skip_count=0; done one cycle after row 1 beat.
- K=3 with middle vector act_zero=1 (data garbage 0x7F) → identical results to K=2 without it; skip_count=1.
- Overflow: DATA_W=8, ACC_W=16, w=-128, a=-128, K=3 → 49152 wraps to 0xC000 (-16384).
- cfg_k=0 → LOAD_W → FLUSH → DRAIN, all res_data=0, done asserted.
- res_ready low 5 cycles on row 1 → res_row/res_data stable; random wgt_valid/act_valid gaps → same results.
- rst_n=0 for one cycle mid-STREAM → all outputs at reset values the next cycle; following clean tile correct.
